// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_pkg
// Purpose  : Shared types and helpers for the BRAM ROM arbiter.
//            - lock_state_t : lock FSM state encoding (UNLOCKED / LOCKED)
//            - idx_width()  : requester-index width, never less than 1 bit
//            - wrap_inc()   : modulo-n increment used by the round-robin pointer
// Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // A single requester still needs a 1-bit index so that vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int k, input int n);
        return (k >= n - 1) ? 0 : k + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotate-priority encoder. Searches req starting at
//            index ptr, wrapping modulo N, and returns the first hit.
// Ports    : req [N-1:0]  - request vector
//            ptr [IW-1:0] - highest-priority index (0..N-1)
//            gnt [N-1:0]  - one-hot winner (zero when no request)
//            idx [IW-1:0] - encoded winner (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = IW'((int'(ptr) + i) % N);
            if (!w_found && req[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_rom_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous-read BRAM ROM among
//            NumReq_p requesters, with optional per-requester locking and a
//            two-stage tag pipeline that routes returned words back.
// Ports    : clk_i       - clock (shared with the ROM)
//            rst_i       - synchronous active-high reset
//            req_i       - per-requester read request, held until granted
//            lock_i      - per-requester lock, sampled for the current owner
//            addr_i      - packed addresses, requester k at [k*memSize_p +:]
//            gnt_o       - one-hot combinational grant
//            rvalid_o    - one-hot registered return strobe
//            rdata_o     - registered read data, broadcast
//            rom_addr_o  - combinational ROM address
//            rom_data_i  - ROM read data (one-cycle registered in the ROM)
// Revision : 1.0 - initial release
// ============================================================================
module bram_rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NumReq_p    = 2,
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq_p-1:0]           req_i,
    input  logic [NumReq_p-1:0]           lock_i,
    input  logic [NumReq_p*memSize_p-1:0] addr_i,
    output logic [NumReq_p-1:0]           gnt_o,
    output logic [NumReq_p-1:0]           rvalid_o,
    output logic [dataWidth_p-1:0]        rdata_o,
    output logic [memSize_p-1:0]          rom_addr_o,
    input  logic [dataWidth_p-1:0]        rom_data_i
);

    localparam int c_IDX_W = idx_width(NumReq_p);

    lock_state_t           r_state;
    logic [NumReq_p-1:0]   r_owner_oh;
    logic [c_IDX_W-1:0]    r_owner_idx;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [NumReq_p-1:0]   r_tag1;

    logic [NumReq_p-1:0]   w_arb_req;
    logic [NumReq_p-1:0]   w_gnt;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_any;
    logic                  w_win_lock;
    logic                  w_owner_lock;

    // Grants are suppressed during reset; while locked only the owner may
    // compete, so the others wait even when the owner is idle.
    always_comb begin
        w_arb_req = req_i;
        if (rst_i) begin
            w_arb_req = '0;
        end else if (r_state == LOCKED) begin
            w_arb_req = req_i & r_owner_oh;
        end
    end

    rr_arbiter #(
        .N  (NumReq_p),
        .IW (c_IDX_W)
    ) u_rr_arbiter (
        .req (w_arb_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign gnt_o        = w_gnt;
    assign w_any        = |w_gnt;
    assign w_win_lock   = |(lock_i & w_gnt);
    assign w_owner_lock = |(lock_i & r_owner_oh);

    // One-hot address mux; zero when nothing is granted.
    always_comb begin
        rom_addr_o = '0;
        for (int k = 0; k < NumReq_p; k++) begin
            if (w_gnt[k]) begin
                rom_addr_o = addr_i[k*memSize_p +: memSize_p];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= UNLOCKED;
            r_owner_oh  <= '0;
            r_owner_idx <= '0;
            r_ptr       <= '0;
            r_tag1      <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
        end else begin
            // Stage 1 tags the ROM access issued this cycle; stage 2 lines
            // the tag up with the word the ROM presents one cycle later.
            r_tag1   <= w_gnt;
            rvalid_o <= r_tag1;
            if (|r_tag1) begin
                rdata_o <= rom_data_i;
            end

            case (r_state)
                UNLOCKED: begin
                    if (w_any) begin
                        r_ptr <= c_IDX_W'(wrap_inc(int'(w_idx), NumReq_p));
                        if (w_win_lock) begin
                            r_state     <= LOCKED;
                            r_owner_oh  <= w_gnt;
                            r_owner_idx <= w_idx;
                        end
                    end
                end
                LOCKED: begin
                    // The owner's grant in the release cycle is already
                    // served; the others resume from the slot after it.
                    if (!w_owner_lock) begin
                        r_state <= UNLOCKED;
                        r_ptr   <= c_IDX_W'(wrap_inc(int'(r_owner_idx), NumReq_p));
                    end
                end
                default: begin
                    r_state <= UNLOCKED;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_rom_arbiter
// Purpose  : Directed self-checking bench for bram_rom_arbiter. Two instances
//            (2 and 4 requesters) each front a behavioural one-cycle ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [1:0]  req2, lock2, gnt2, rvalid2;
    logic [15:0] addr2;
    logic [7:0]  rom_addr2;
    logic [15:0] rdata2, rom_data2;

    logic [3:0]  req4, lock4, gnt4, rvalid4;
    logic [31:0] addr4;
    logic [7:0]  rom_addr4;
    logic [15:0] rdata4, rom_data4;

    int tests = 0;
    int fails = 0;

    logic [3:0] fair_exp  [0:10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2,
                                     4'h4, 4'h8, 4'h1, 4'h2, 4'h8};
    logic [7:0] fair_addr [0:10] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50, 8'h51,
                                     8'h52, 8'h53, 8'h50, 8'h51, 8'h53};

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        if (a == 8'h12) return 16'hBEEF;
        return {a ^ 8'hA5, a};
    endfunction

    // Behavioural ROM: registered read, one cycle latency.
    always @(posedge clk) begin
        rom_data2 <= rom_word(rom_addr2);
        rom_data4 <= rom_word(rom_addr4);
    end

    bram_rom_arbiter #(.NumReq_p(2), .memSize_p(8), .dataWidth_p(16)) u_dut2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req2),
        .lock_i     (lock2),
        .addr_i     (addr2),
        .gnt_o      (gnt2),
        .rvalid_o   (rvalid2),
        .rdata_o    (rdata2),
        .rom_addr_o (rom_addr2),
        .rom_data_i (rom_data2)
    );

    bram_rom_arbiter #(.NumReq_p(4), .memSize_p(8), .dataWidth_p(16)) u_dut4 (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req4),
        .lock_i     (lock4),
        .addr_i     (addr4),
        .gnt_o      (gnt4),
        .rvalid_o   (rvalid4),
        .rdata_o    (rdata4),
        .rom_addr_o (rom_addr4),
        .rom_data_i (rom_data4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req2 = '0; lock2 = '0; addr2 = '0;
        req4 = '0; lock4 = '0; addr4 = '0;
        step; step;

        // Reset state, with a request present that must not be granted
        req2 = 2'b01; addr2 = 16'h0012; #1;
        chk("rst_gnt2",    gnt2,      32'h0);
        chk("rst_addr2",   rom_addr2, 32'h0);
        chk("rst_rvalid2", rvalid2,   32'h0);
        chk("rst_rdata2",  rdata2,    32'h0);
        chk("rst_gnt4",    gnt4,      32'h0);
        chk("rst_rvalid4", rvalid4,   32'h0);
        chk("rst_rdata4",  rdata4,    32'h0);

        // Single request: grant in the cycle reset falls, data two cycles on
        rst = 1'b0; #1;
        chk("single_gnt",  gnt2,      32'h1);
        chk("single_addr", rom_addr2, 32'h12);
        step; req2 = 2'b00; #1;
        chk("single_rvalid_t1", rvalid2, 32'h0);
        chk("single_gnt_t1",    gnt2,    32'h0);
        step; #1;
        chk("single_rvalid_t2", rvalid2, 32'h1);
        chk("single_rdata_t2",  rdata2,  32'hBEEF);

        // Idle: nothing granted, data held
        for (int i = 0; i < 10; i++) begin
            step; #1;
            chk("idle_gnt",    gnt2,      32'h0);
            chk("idle_addr",   rom_addr2, 32'h0);
            chk("idle_rvalid", rvalid2,   32'h0);
            chk("idle_rdata",  rdata2,    32'hBEEF);
        end

        // Reset mid-flight (pointer now favours requester 1)
        step; req2 = 2'b10; addr2 = 16'h3300; #1;
        chk("rmf_gnt",  gnt2,      32'h2);
        chk("rmf_addr", rom_addr2, 32'h33);
        step; req2 = 2'b00; rst = 1'b1; #1;
        chk("rmf_gnt_t1",    gnt2,    32'h0);
        chk("rmf_rvalid_t1", rvalid2, 32'h0);
        step; rst = 1'b0; #1;
        chk("rmf_rvalid_t2", rvalid2, 32'h0);
        chk("rmf_rdata_t2",  rdata2,  32'h0);
        step; #1;
        chk("rmf_rvalid_t3", rvalid2, 32'h0);
        chk("rmf_rdata_t3",  rdata2,  32'h0);

        // Contention: both request every cycle, pointer reset to 0
        step; req2 = 2'b11; addr2 = 16'h2010;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) req2 = 2'b00;
            #1;
            chk("cont_gnt", gnt2, (i >= 6) ? 32'h0 : ((i % 2 == 1) ? 32'h2 : 32'h1));
            if (i < 6)
                chk("cont_addr", rom_addr2, (i % 2 == 1) ? 32'h20 : 32'h10);
            if (i >= 2) begin
                chk("cont_rvalid", rvalid2, (i % 2 == 1) ? 32'h2 : 32'h1);
                chk("cont_rdata",  rdata2,  rom_word((i % 2 == 1) ? 8'h20 : 8'h10));
            end
            step;
        end

        // Lock: requester 1 takes four grants, requester 0 waits
        req2 = 2'b10; lock2 = 2'b10; addr2 = 16'h4000; #1;
        chk("lock_g1", gnt2, 32'h2);
        step; req2 = 2'b11; #1;
        chk("lock_g2", gnt2, 32'h2);
        step; #1;
        chk("lock_g3", gnt2, 32'h2);
        step; req2 = 2'b01; #1;
        chk("lock_owner_idle", gnt2, 32'h0);
        step; req2 = 2'b11; lock2 = 2'b00; #1;
        chk("lock_g4_release", gnt2, 32'h2);
        step; #1;
        chk("lock_after", gnt2, 32'h1);
        step; req2 = 2'b00;

        // Fairness wrap on four requesters, then requester 2 drops out
        req4 = 4'hF; addr4 = 32'h5352_5150;
        for (int i = 0; i < 13; i++) begin
            if (i == 7)  req4 = 4'b1011;
            if (i == 11) req4 = 4'b0000;
            #1;
            chk("fair_gnt", gnt4, (i < 11) ? 32'(fair_exp[i]) : 32'h0);
            if (i < 11)
                chk("fair_addr", rom_addr4, fair_addr[i]);
            if (i >= 2) begin
                chk("fair_rvalid", rvalid4, fair_exp[i-2]);
                chk("fair_rdata",  rdata4,  rom_word(fair_addr[i-2]));
            end
            step;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_rom_arbiter.md
# bram_rom_arbiter

Shares a single synchronous-read BRAM ROM (`bram_init`, one-cycle registered read) between several requesters, e.g. instruction fetch and a data/const-table port. Requesters post addresses under a request/grant handshake; a round-robin arbiter picks one per cycle, drives the ROM address, and routes the returned word back with a per-requester valid strobe. Optional locking lets one requester stream consecutive reads without interleaving. Sits directly in front of the ROM instance; one arbiter per ROM.

## Interface
- `NumReq_p`, 2: number of requesters (2–8).
- `memSize_p`, 8: ROM address width; must match the ROM instance.
- `dataWidth_p`, 16: ROM word width; must match the ROM instance.
- `clk_i`  input  1  sole clock; ROM shares it.
- `rst_i`  input  1  reset, synchronous, active-high.
- `req_i`  input  NumReq_p  per-requester read request; held until granted.
- `lock_i`  input  NumReq_p  per-requester lock; sampled only for the current grant winner.
- `addr_i`  input  NumReq_p*memSize_p  packed addresses, requester k at bits [k*memSize_p +: memSize_p].
- `gnt_o`  output  NumReq_p  one-hot, combinational; request accepted this cycle.
- `rvalid_o`  output  NumReq_p  one-hot, registered; `rdata_o` belongs to this requester.
- `rdata_o`  output  dataWidth_p  registered read data, broadcast to all requesters.
- `rom_addr_o`  output  memSize_p  to ROM `addr_i`; combinational.
- `rom_data_i`  input  dataWidth_p  from ROM `data_o`.

## Operation
- Arbitration every cycle among asserted `req_i`; at most one `gnt_o` bit high; `gnt_o[k]` implies `req_i[k]`.
- Round-robin: pointer `ptr` names highest-priority index; search ptr, ptr+1, … wrapping modulo NumReq_p. After a grant to k, `ptr` ← (k+1) mod NumReq_p.
- Lock state machine, states UNLOCKED / LOCKED(owner):
  - UNLOCKED: normal round-robin. If winner k has `lock_i[k]`=1, go LOCKED(k).
  - LOCKED(k): only requester k can be granted; others wait even if k idles. `ptr` not updated. Exit to UNLOCKED when `lock_i[k]`=0 (grant in that cycle still goes to k if `req_i[k]`); `ptr` ← (k+1) mod NumReq_p on exit.
- `rom_addr_o` = winner's address when any grant, else all zeros.
- Tag pipeline: stage-1 register holds one-hot winner (zero if none); stage-2 registers `rom_data_i` into `rdata_o` and stage-1 tag into `rvalid_o`.
- `rdata_o` updates only when stage-1 tag nonzero; otherwise holds.
- Full throughput: one grant per cycle sustained, no bubbles.
- No backpressure on return: requesters must accept `rvalid_o` when it fires.

## Timing
- Grant in cycle t (combinational, same cycle as `req_i` visible); requester may change `addr_i`/drop `req_i` from t+1.
- ROM registers data at edge ending t; `rom_data_i` valid during t+1.
- `rvalid_o`/`rdata_o` valid during t+2. Latency request-grant 0, grant-data 2 cycles.
- Reset values: `gnt_o`=0 while `rst_i`=1 (grants suppressed), `rvalid_o`=0, `rdata_o`=0, `ptr`=0, state UNLOCKED, tag stages 0, `rom_addr_o`=0.
- Reset mid-operation: in-flight tags cleared; no `rvalid_o` for any grant issued before reset, even though ROM still returns data. First grant possible in the cycle `rst_i` falls.
- Simultaneous `lock_i` drop and new requests from others: owner's final grant served that cycle; others arbitrate from next cycle starting at (k+1).
- NumReq_p=1: always grants requester 0 when requesting; lock has no observable effect.

## Structure
- Package `rom_arb_pkg`: requester-index width (`$clog2(NumReq_p)`, min 1), lock state enum (UNLOCKED, LOCKED).
- Sub-module `rr_arbiter`: parameter N; inputs `req`, `ptr`; output one-hot `gnt` and encoded index. Purely combinational rotate-priority-encode; pointer/lock state live in the top block.
- Top: lock FSM, pointer register, address mux, two-stage tag pipeline, data register.

## Test plan
- Single request: NumReq_p=2, ROM word 0x12=0xBEEF; `req_i`=01, addr0=0x12 -> `gnt_o`=01 in t, `rvalid_o`=01 with `rdata_o`=0xBEEF in t+2.
- Contention: both request every cycle, addr0=0x10, addr1=0x20 -> grants alternate 01,10,01,10; returns alternate ROM[0x10],ROM[0x20] at 2-cycle lag, no gaps.
- Fairness wrap, NumReq_p=4: all request, grants 0,1,2,3,0; drop req2 -> order 3,0,1,3.
- Lock: requester 1 holds `lock_i[1]`=1 for 4 grants while requester 0 requests -> 4 consecutive `gnt_o`=10, requester 0 granted in cycle after lock drops.
- Reset mid-flight: grant at t, `rst_i`=1 in t+1 -> `rvalid_o` stays 0 through t+3; `rdata_o`=0.
- Idle: `req_i`=0 for 10 cycles -> `gnt_o`=0, `rom_addr_o`=0, `rvalid_o`=0, `rdata_o` unchanged.
